postprocess_q6_10_to_gray: RTL and testbench
============================================

Name: postprocess_q6_10_to_gray

Overview:
- Output-side counterpart of the input normaliser in the CNN reasoning path.
- Takes Q6.10 signed fixed-point samples in the range 0.0–1.0 nominal, de-normalises them (×255), rounds, saturates, and emits 8-bit grayscale pixels.
- Used to write reconstructed or feature-map images back to the display/frame buffer.
- Stall-capable 3-stage pipeline with valid/ready on both sides and a per-frame pixel counter that marks the last pixel.

Parameters:
- FRAC_BITS, 10, fractional bits of the input format (Q6.10).
- PIX_PER_FRAME, 784, pixels per frame (28×28); sets the data_out_last position.
- CNT_W, 10, pixel counter width; must satisfy 2^CNT_W ≥ PIX_PER_FRAME.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  16  Q6.10 signed sample.
- data_in_valid  in  1  data_in is valid.
- data_in_ready  out  1  block accepts data_in this cycle.
- data_out  out  8  unsigned grayscale pixel.
- data_out_valid  out  1  data_out is valid.
- data_out_ready  in  1  downstream accepts data_out.
- data_out_last  out  1  high with the PIX_PER_FRAME-th pixel of a frame.
- data_out_sat  out  1  high when this pixel was clipped (input <0 or result >255).

Behaviour:
- Reset: clk and reset are as already decided (one clock; rst_n asynchronous, active-low). All stage valid bits, data registers, the pixel counter, data_out, data_out_valid, data_out_last and data_out_sat reset to 0. Reset asserted mid-operation discards all in-flight samples; no partial frame is reported after release.
- Pipeline enable: en = !data_out_valid || data_out_ready.
  - data_in_ready = en (combinational).
  - All three stages advance only when en=1; a stage holding valid=0 still shifts (bubbles are not collapsed).
- Input handshake: a sample is accepted when data_in_valid && data_in_ready.
- Stage 1: register data_in and its valid bit.
- Stage 2: p = x × 255, signed 24-bit, computed as (x<<8) − x; no overflow is possible at 24 bits.
- Stage 3:
  - r = (p + 2^(FRAC_BITS−1)) >>> FRAC_BITS, arithmetic shift (round half up).
  - If r < 0, out = 0 and sat = 1.
  - Else if r > 255, out = 255 and sat = 1.
  - Else out = r[7:0] and sat = 0.
- Latency: exactly 3 cycles from the input handshake to data_out_valid when data_out_ready is held high. Throughput is 1 sample/cycle.
- Output hold: while data_out_valid && !data_out_ready, data_out, data_out_last and data_out_sat are held stable. No input is accepted.
- Pixel counter:
  - Increments on each output handshake (data_out_valid && data_out_ready).
  - data_out_last = data_out_valid && (cnt == PIX_PER_FRAME−1).
  - On the handshake of the last pixel, cnt wraps to 0. Back-to-back frames need no gap.
- Simultaneous events: an output handshake and an input handshake in the same cycle are both honoured (a full pipeline streams). A stalled output never blocks counter correctness, because the counter moves only on handshakes.
- Input-valid rule: data_in must be stable while data_in_valid=1 and data_in_ready=0 (AXI-stream rule). The block does not re-check this.

Decomposition:
- Package cnn_fixed_pkg holds:
  - FRAC_BITS = 10, Q_W = 16, PIX_W = 8, GAIN = 255, PIX_PER_FRAME = 784.
  - Function sat_u8(signed) returning {sat, u8}.
- One sub-module, q6_10_denorm_core: stages 2–3 arithmetic (multiply, round, saturate), with an enable input. The top level owns the handshake, stage 1 and the pixel counter.

Test Plan:
- Pixel values with ready=1: feed 0x0000, 0x0200, 0x0400, 0x0003 → 0, 128, 255, 1 with sat=0. data_out_valid goes high 3 cycles after the first accept.
- Saturation: feed 0xFC00 (−1.0) and 0x0800 (2.0) → 0 and 255, each with sat=1. Feed 0x0001 → 0 with sat=0 (rounds down, not clipped).
- Backpressure: stream 10 samples with data_out_ready toggling 1,0,0,1 → data_in_ready equals the output-empty-or-ready condition. data_out is stable during stalls. All 10 outputs arrive in order with no loss or duplication.
- Frame marker: stream 1568 samples continuously → data_out_last high exactly on output #784 and #1568. The counter returns to 0 after each.
- Reset mid-frame: pull rst_n low after 300 outputs while 3 samples are in flight → outputs go to 0 asynchronously. After release, the next 784 outputs end with data_out_last on the 784th.
- Random stress: 10k random Q6.10 values with random valid/ready → compare against a reference model of clamp(floor((x×255+512)/1024), 0, 255) and the sat flag.

Source files
------------

// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point constants and helpers for the CNN pixel path.
// Q6.10 samples are de-normalised to 8-bit grayscale via a 24-bit signed product.
package cnn_fixed_pkg;

    localparam int unsigned FRAC_BITS     = 10;
    localparam int unsigned Q_W           = 16;
    localparam int unsigned PIX_W         = 8;
    localparam int unsigned GAIN          = 255;
    localparam int unsigned GAIN_SHIFT    = 8;   // GAIN == 2^GAIN_SHIFT - 1
    localparam int unsigned PIX_PER_FRAME = 784;
    localparam int unsigned PROD_W        = 24;

    localparam logic signed [PROD_W-1:0] PIX_MAX = PROD_W'(GAIN);

    typedef struct packed {
        logic             sat;
        logic [PIX_W-1:0] pix;
    } pix_sat_t;

    // Clamp a signed rounded value into [0, 255], flagging any clipping.
    function automatic pix_sat_t sat_u8(input logic signed [PROD_W-1:0] r);
        pix_sat_t res;
        res.sat = 1'b0;
        res.pix = '0;
        if (r < 0) begin
            res.sat = 1'b1;
            res.pix = '0;
        end else if (r > PIX_MAX) begin
            res.sat = 1'b1;
            res.pix = '1;
        end else begin
            res.pix = r[PIX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/q6_10_denorm_core.sv
// Two-stage de-normalise datapath: x*255, then round-half-up, shift and saturate to u8.
// Both stages advance together on en; invalid slots shift through as bubbles.
module q6_10_denorm_core #(
    parameter int unsigned FRAC_BITS = cnn_fixed_pkg::FRAC_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [cnn_fixed_pkg::Q_W-1:0]   x,
    input  logic                            x_valid,
    output logic [cnn_fixed_pkg::PIX_W-1:0] pix,
    output logic                            pix_sat,
    output logic                            pix_valid
);
    import cnn_fixed_pkg::*;

    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (FRAC_BITS - 1);

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     prod_valid_q;

    logic signed [PROD_W-1:0] rnd_sum;
    logic signed [PROD_W-1:0] rnd;
    pix_sat_t                 res;

    logic [PIX_W-1:0] pix_q;
    logic             sat_q;
    logic             pix_valid_q;

    // x*255 as (x<<8) - x; the 24-bit range covers the full Q6.10 input span.
    always_comb begin
        x_ext  = {{(PROD_W - Q_W){x[Q_W-1]}}, x};
        prod_d = (x_ext <<< GAIN_SHIFT) - x_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else if (en) begin
            prod_q       <= prod_d;
            prod_valid_q <= x_valid;
        end
    end

    always_comb begin
        rnd_sum = prod_q + ROUND_BIAS;
        rnd     = rnd_sum >>> FRAC_BITS;
        res     = sat_u8(rnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q       <= '0;
            sat_q       <= 1'b0;
            pix_valid_q <= 1'b0;
        end else if (en) begin
            pix_q       <= res.pix;
            sat_q       <= res.sat;
            pix_valid_q <= prod_valid_q;
        end
    end

    assign pix       = pix_q;
    assign pix_sat   = sat_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: rtl/postprocess_q6_10_to_gray.sv
// Q6.10 -> 8-bit grayscale output stage: 3-deep stallable pipeline with valid/ready
// on both sides and a per-frame pixel counter driving data_out_last.
module postprocess_q6_10_to_gray #(
    parameter int unsigned FRAC_BITS     = cnn_fixed_pkg::FRAC_BITS,
    parameter int unsigned PIX_PER_FRAME = cnn_fixed_pkg::PIX_PER_FRAME,
    parameter int unsigned CNT_W         = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [cnn_fixed_pkg::Q_W-1:0]   data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [cnn_fixed_pkg::PIX_W-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last,
    output logic                            data_out_sat
);
    import cnn_fixed_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_PER_FRAME - 1);

    logic en;
    logic out_hs;

    logic [Q_W-1:0] s1_data_q;
    logic           s1_valid_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The whole pipeline moves as one; bubbles are kept rather than collapsed.
    assign en            = !data_out_valid || data_out_ready;
    assign data_in_ready = en;
    assign out_hs        = data_out_valid && data_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else if (en) begin
            s1_data_q  <= data_in;
            s1_valid_q <= data_in_valid;
        end
    end

    q6_10_denorm_core #(
        .FRAC_BITS (FRAC_BITS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .x         (s1_data_q),
        .x_valid   (s1_valid_q),
        .pix       (data_out),
        .pix_sat   (data_out_sat),
        .pix_valid (data_out_valid)
    );

    // Counter only moves on output handshakes, so stalls cannot skew the frame position.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_out_last = data_out_valid && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_postprocess_q6_10_to_gray.sv
// Directed and randomised checks of the Q6.10 -> grayscale output pipeline.
module tb_postprocess_q6_10_to_gray;

    localparam int PPF = 784;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;
    logic        data_out_sat;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    int         mcnt;

    logic [15:0] vin_a[16];
    logic [8:0]  got_a[16];
    int          got_n;
    int          first_valid;

    postprocess_q6_10_to_gray #(
        .FRAC_BITS     (10),
        .PIX_PER_FRAME (PPF),
        .CNT_W         (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last),
        .data_out_sat   (data_out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: clamp(floor((x*255 + 512) / 1024), 0, 255) with clip flag.
    function automatic logic [8:0] ref_pix(input logic [15:0] x);
        int t;
        int r;
        t = $signed(x) * 255 + 512;
        if (t >= 0) r = t / 1024;
        else r = -((-t + 1023) / 1024);
        if (r < 0) return {1'b1, 8'd0};
        if (r > 255) return {1'b1, 8'd255};
        return {1'b0, r[7:0]};
    endfunction

    // Drive inputs at the falling edge, then sample what the next rising edge will do.
    task automatic cycle(input logic v, input logic [15:0] d, input logic rdy,
                         output logic in_hs, output logic out_hs);
        @(negedge clk);
        data_in_valid  = v;
        data_in        = d;
        data_out_ready = rdy;
        #1;
        in_hs  = data_in_valid && data_in_ready;
        out_hs = data_out_valid && data_out_ready;
    endtask

    task automatic model(input logic in_hs, input logic [15:0] d, input logic out_hs,
                         output logic [8:0] exp_v, output logic exp_last, output logic have);
        have     = 1'b0;
        exp_v    = '0;
        exp_last = 1'b0;
        if (out_hs) begin
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                have  = 1'b1;
            end
            exp_last = (mcnt == PPF - 1);
            mcnt     = exp_last ? 0 : mcnt + 1;
        end
        if (in_hs) exp_q.push_back(ref_pix(d));
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mcnt = 0;
    endtask

    // Feeds vin_a[0..n-1] back-to-back with ready high, recording outputs in got_a.
    task automatic run_directed(input int n);
        logic ih, oh;
        got_n       = 0;
        first_valid = -1;
        for (int c = 0; c < n + 10; c++) begin
            cycle(c < n, (c < n) ? vin_a[c] : 16'h0000, 1'b1, ih, oh);
            if (data_out_valid && first_valid < 0) first_valid = c;
            if (oh && got_n < 16) begin
                got_a[got_n] = {data_out_sat, data_out};
                got_n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        #1;
        checks++;
        if ({data_out_valid, data_out, data_out_last, data_out_sat, data_in_ready} !== 12'h001) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%b rdy=%b, want 0 00 0 0 1",
                     data_out_valid, data_out, data_out_last, data_out_sat, data_in_ready);
        end
        apply_reset();
        @(posedge clk);
        #1;
        checks++;
        if (data_out_valid !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got v=%b d=%h, want 0 00", data_out_valid, data_out);
        end
    endtask

    task automatic test_pixel_values();
        logic [8:0] exp_a[4] = '{9'h000, 9'h080, 9'h0FF, 9'h001};
        apply_reset();
        vin_a[0] = 16'h0000;
        vin_a[1] = 16'h0200;
        vin_a[2] = 16'h0400;
        vin_a[3] = 16'h0003;
        run_directed(4);
        checks++;
        if (first_valid !== 3) begin
            errors++;
            $display("FAIL latency: got first valid at cycle %0d, want 3", first_valid);
        end
        checks++;
        if (got_n !== 4) begin
            errors++;
            $display("FAIL pixel_count: got %0d outputs, want 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL pixel_value[%0d]: got sat/pix %h, want %h", i, got_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] exp_a[3] = '{9'h100, 9'h1FF, 9'h000};
        apply_reset();
        vin_a[0] = 16'hFC00;
        vin_a[1] = 16'h0800;
        vin_a[2] = 16'h0001;
        run_directed(3);
        checks++;
        if (got_n !== 3) begin
            errors++;
            $display("FAIL sat_count: got %0d outputs, want 3", got_n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL sat_value[%0d]: got sat/pix %h, want %h", i, got_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_a[10] = '{9'h000, 9'h020, 9'h040, 9'h060, 9'h080,
                                  9'h09F, 9'h0BF, 9'h0DF, 9'h0FF, 9'h1FF};
        logic       ih, oh, rp;
        logic       prev_stall;
        logic [9:0] prev_out;
        int         k;
        int         c;
        apply_reset();
        k          = 0;
        got_n      = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        c          = 0;
        while (got_n < 10 && c < 200) begin
            rp = (c % 4 == 0) || (c % 4 == 3);
            cycle(k < 10, (k < 10) ? 16'(k * 16'h0080) : 16'h0000, rp, ih, oh);
            checks++;
            if (data_in_ready !== (!data_out_valid || data_out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready: cycle %0d got %b, want %b", c, data_in_ready,
                         !data_out_valid || data_out_ready);
            end
            if (prev_stall) begin
                checks++;
                if ({data_out_valid, data_out_sat, data_out} !== {1'b1, prev_out[8:0]}) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got v=%b sat/pix %h, want 1 %h", c,
                             data_out_valid, {data_out_sat, data_out}, prev_out[8:0]);
                end
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_out   = {1'b0, data_out_sat, data_out};
            if (ih) k++;
            if (oh) begin
                got_a[got_n] = {data_out_sat, data_out};
                got_n++;
            end
            c++;
        end
        checks++;
        if (got_n !== 10) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, want 10", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL bp_value[%0d]: got sat/pix %h, want %h", i, got_a[i], exp_a[i]);
            end
        end
        // Drain so no stray output stays pending.
        repeat (4) cycle(1'b0, 16'h0000, 1'b1, ih, oh);
    endtask

    task automatic test_frame_marker();
        logic        ih, oh, el, have;
        logic [8:0]  ev;
        logic [15:0] d;
        int          k, outs, lasts;
        apply_reset();
        k     = 0;
        outs  = 0;
        lasts = 0;
        for (int c = 0; c < 2 * PPF + 50 && outs < 2 * PPF; c++) begin
            d = 16'(k * 53) & 16'h07FF;
            cycle(k < 2 * PPF, d, 1'b1, ih, oh);
            model(ih, d, oh, ev, el, have);
            if (ih) k++;
            if (oh) begin
                checks++;
                if (!have || {data_out_sat, data_out} !== ev || data_out_last !== el) begin
                    errors++;
                    $display("FAIL frame_out[%0d]: got sat/pix %h last %b, want %h last %b (have %b)",
                             outs, {data_out_sat, data_out}, data_out_last, ev, el, have);
                end
                if (data_out_last) lasts++;
                outs++;
            end
        end
        checks++;
        if (outs !== 2 * PPF || lasts !== 2) begin
            errors++;
            $display("FAIL frame_totals: got %0d outputs %0d lasts, want %0d and 2",
                     outs, lasts, 2 * PPF);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic        ih, oh, el, have;
        logic [8:0]  ev;
        logic [15:0] d;
        int          outs, k, lasts, last_at;
        apply_reset();
        outs = 0;
        for (int c = 0; c < 400 && outs < 300; c++) begin
            cycle(1'b1, 16'h0400, 1'b1, ih, oh);
            if (oh) outs++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out_valid, data_out, data_out_last, data_out_sat} !== 11'h000) begin
            errors++;
            $display("FAIL midreset_async: got v=%b d=%h l=%b s=%b, want all 0",
                     data_out_valid, data_out, data_out_last, data_out_sat);
        end
        data_in_valid = 1'b0;
        exp_q.delete();
        mcnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        outs    = 0;
        lasts   = 0;
        last_at = -1;
        for (int c = 0; c < PPF + 50 && outs < PPF; c++) begin
            d = 16'((k * 7) & 16'h03FF);
            cycle(k < PPF, d, 1'b1, ih, oh);
            model(ih, d, oh, ev, el, have);
            if (ih) k++;
            if (oh) begin
                checks++;
                if (!have || {data_out_sat, data_out} !== ev || data_out_last !== el) begin
                    errors++;
                    $display("FAIL midreset_out[%0d]: got sat/pix %h last %b, want %h last %b",
                             outs, {data_out_sat, data_out}, data_out_last, ev, el);
                end
                if (data_out_last) begin
                    lasts++;
                    last_at = outs;
                end
                outs++;
            end
        end
        checks++;
        if (outs !== PPF || lasts !== 1 || last_at !== PPF - 1) begin
            errors++;
            $display("FAIL midreset_frame: got %0d outs, %0d lasts at %0d, want %0d, 1 at %0d",
                     outs, lasts, last_at, PPF, PPF - 1);
        end
    endtask

    task automatic test_random();
        logic        ih, oh, el, have, v, rdy;
        logic [8:0]  ev;
        logic [15:0] d;
        int          acc, outs, c;
        apply_reset();
        acc  = 0;
        outs = 0;
        v    = 1'b0;
        d    = '0;
        c    = 0;
        while ((acc < 10000 || exp_q.size() > 0) && c < 60000) begin
            if (!v && acc < 10000 && $urandom_range(0, 3) != 0) begin
                v = 1'b1;
                d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0440))
                                                : 16'($urandom);
            end
            rdy = (acc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cycle(v, d, rdy, ih, oh);
            model(ih, d, oh, ev, el, have);
            if (oh) begin
                checks++;
                if (!have || {data_out_sat, data_out} !== ev || data_out_last !== el) begin
                    errors++;
                    $display("FAIL random_out[%0d]: got sat/pix %h last %b, want %h last %b (have %b)",
                             outs, {data_out_sat, data_out}, data_out_last, ev, el, have);
                end
                outs++;
            end
            if (ih) begin
                acc++;
                v = 1'b0;
            end
            c++;
        end
        checks++;
        if (acc !== 10000 || outs !== 10000) begin
            errors++;
            $display("FAIL random_totals: got %0d accepted %0d out, want 10000 each", acc, outs);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        test_reset();
        test_pixel_values();
        test_saturation();
        test_backpressure();
        test_frame_marker();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
